// File: rtl/adxl362_pkg.sv
// Shared definitions for the ADXL362 behavioural model: FIFO mode
// encodings and default FIFO geometry.
package adxl362_pkg;

    typedef enum logic [1:0] {
        FIFO_MODE_DISABLED = 2'b00,
        FIFO_MODE_OLDEST   = 2'b01,
        FIFO_MODE_STREAM   = 2'b10
    } fifo_mode_e;

    localparam int ADXL362_FIFO_DEPTH   = 512;
    localparam int ADXL362_SAMPLE_WIDTH = 8;

endpackage

// File: rtl/adxl362_fifo_mem.sv
// Simple dual-port sample store: synchronous write port, asynchronous read
// port. Contents are never reset.
module adxl362_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 512
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the incoming word on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adxl362_sync_fifo.sv
// Single-clock ADXL362 sample FIFO with disabled / oldest-saved / stream
// modes, count and watermark status, and sticky overrun/underrun flags.
module adxl362_sync_fifo
    import adxl362_pkg::*;
#(
    parameter int DATA_WIDTH = ADXL362_SAMPLE_WIDTH,
    parameter int DEPTH      = ADXL362_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [1:0]                 mode,
    input  logic [$clog2(DEPTH):0]     watermark,
    input  logic                       write,
    input  logic [DATA_WIDTH-1:0]      data_wr,
    input  logic                       read,
    output logic [DATA_WIDTH-1:0]      data_rd,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       watermark_hit,
    output logic                       overrun,
    output logic                       underrun
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   count;

    logic enabled;
    logic stream;
    logic do_read;
    logic do_store;
    logic stream_drop;
    logic count_inc;
    logic overrun_set;
    logic underrun_set;

    assign fifo_empty    = (count == '0);
    assign fifo_full     = (count == FULL_COUNT);
    assign fifo_count    = count;
    assign watermark_hit = (watermark != '0) && (count >= watermark);

    // Decode the mode and derive this cycle's pointer/count/flag actions.
    // A full oldest-saved FIFO still accepts a write when a pop frees the
    // slot in the same cycle; a full stream FIFO without a pop discards
    // its oldest entry instead.
    always_comb begin
        enabled = 1'b0;
        stream  = 1'b0;
        case (mode)
            FIFO_MODE_OLDEST: enabled = 1'b1;
            FIFO_MODE_STREAM: begin
                enabled = 1'b1;
                stream  = 1'b1;
            end
            default: ;
        endcase
        do_read      = read && !fifo_empty;
        do_store     = write && enabled && (!fifo_full || stream || read);
        stream_drop  = write && stream && fifo_full && !read;
        count_inc    = do_store && !stream_drop;
        overrun_set  = write && enabled && fifo_full && !read;
        underrun_set = read && fifo_empty;
    end

    // Pointer, count and sticky flag registers; reset beats flush beats
    // read/write.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (do_store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read || stream_drop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (count_inc && !do_read) begin
                count <= count + 1'b1;
            end else if (do_read && !count_inc) begin
                count <= count - 1'b1;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end
            if (underrun_set) begin
                underrun <= 1'b1;
            end
        end
    end

    adxl362_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_store && !(reset || flush)),
        .wr_addr (wr_ptr),
        .wr_data (data_wr),
        .rd_addr (rd_ptr),
        .rd_data (data_rd)
    );

endmodule

// File: tb/tb_adxl362_sync_fifo.sv
// Directed self-checking bench for adxl362_sync_fifo using a 4-entry FIFO.
module tb_adxl362_sync_fifo;

    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int AW = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [1:0]    mode;
    logic [AW:0]   watermark;
    logic          write;
    logic [DW-1:0] data_wr;
    logic          read;
    logic [DW-1:0] data_rd;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   fifo_count;
    logic          watermark_hit;
    logic          overrun;
    logic          underrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adxl362_sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .mode          (mode),
        .watermark     (watermark),
        .write         (write),
        .data_wr       (data_wr),
        .read          (read),
        .data_rd       (data_rd),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .fifo_count    (fifo_count),
        .watermark_hit (watermark_hit),
        .overrun       (overrun),
        .underrun      (underrun)
    );

    // Advance one edge; inputs change and outputs are sampled 2 time units later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; write = 1'b0; read = 1'b0;
        data_wr = '0; watermark = '0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        write = 1'b1; data_wr = d;
        cyc();
        write = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [DW-1:0] exp);
        checks++;
        if (data_rd !== exp) begin
            errors++;
            $display("FAIL %s data_rd got %h want %h", name, data_rd, exp);
        end
        read = 1'b1;
        cyc();
        read = 1'b0;
    endtask

    task automatic test_reset();
        mode = 2'b01;
        do_reset();
        checks++;
        if ({fifo_empty, fifo_full, fifo_count, watermark_hit, overrun, underrun} !==
            {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset e=%b f=%b c=%0d wh=%b ov=%b un=%b want e=1 f=0 c=0 wh=0 ov=0 un=0",
                     fifo_empty, fifo_full, fifo_count, watermark_hit, overrun, underrun);
        end
    endtask

    task automatic test_order();
        do_reset();
        mode = 2'b01;
        push(8'h11);
        checks++;
        if (data_rd !== 8'h11 || fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL first_word data_rd got %h empty %b want 11 0", data_rd, fifo_empty);
        end
        push(8'h22);
        push(8'h33);
        checks++;
        if (fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL order_count got %0d want 3", fifo_count);
        end
        pop_expect("order0", 8'h11);
        pop_expect("order1", 8'h22);
        pop_expect("order2", 8'h33);
        checks++;
        if (fifo_count !== 3'd0 || fifo_empty !== 1'b1 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL order_drain c=%0d e=%b un=%b want 0 1 0", fifo_count, fifo_empty, underrun);
        end
    endtask

    task automatic test_oldest_full();
        do_reset();
        mode = 2'b01;
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        checks++;
        if (fifo_full !== 1'b1 || fifo_count !== 3'd4 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL oldest_fill f=%b c=%0d ov=%b want 1 4 0", fifo_full, fifo_count, overrun);
        end
        push(8'hA4);
        checks++;
        if (overrun !== 1'b1 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL oldest_overrun ov=%b c=%0d want 1 4", overrun, fifo_count);
        end
        for (int i = 0; i < 4; i++) pop_expect("oldest_rd", 8'hA0 + 8'(i));
        checks++;
        if (fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL oldest_empty got %b want 1", fifo_empty);
        end
    endtask

    task automatic test_stream();
        do_reset();
        mode = 2'b10;
        for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i));
        checks++;
        if (fifo_count !== 3'd4 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL stream_status c=%0d ov=%b want 4 1", fifo_count, overrun);
        end
        for (int i = 2; i < 6; i++) pop_expect("stream_rd", 8'hB0 + 8'(i));
    endtask

    task automatic test_simul_full();
        do_reset();
        mode = 2'b01;
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        write = 1'b1; read = 1'b1; data_wr = 8'hC9;
        cyc();
        write = 1'b0; read = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || overrun !== 1'b0 || data_rd !== 8'hC1) begin
            errors++;
            $display("FAIL simul_full c=%0d ov=%b d=%h want 4 0 c1", fifo_count, overrun, data_rd);
        end
        pop_expect("simul_rd1", 8'hC1);
        pop_expect("simul_rd2", 8'hC2);
        pop_expect("simul_rd3", 8'hC3);
        pop_expect("simul_rd4", 8'hC9);
        read = 1'b1;
        cyc();
        read = 1'b0;
        checks++;
        if (underrun !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL underrun un=%b c=%0d want 1 0", underrun, fifo_count);
        end
    endtask

    task automatic test_empty_rw();
        do_reset();
        mode = 2'b10;
        write = 1'b1; read = 1'b1; data_wr = 8'h5A;
        cyc();
        write = 1'b0; read = 1'b0;
        checks++;
        if (fifo_count !== 3'd1 || underrun !== 1'b1 || data_rd !== 8'h5A) begin
            errors++;
            $display("FAIL empty_rw c=%0d un=%b d=%h want 1 1 5a", fifo_count, underrun, data_rd);
        end
    endtask

    task automatic test_watermark();
        do_reset();
        mode = 2'b01;
        watermark = 3'd3;
        push(8'h01);
        push(8'h02);
        checks++;
        if (watermark_hit !== 1'b0) begin
            errors++;
            $display("FAIL wm_below got %b want 0", watermark_hit);
        end
        push(8'h03);
        checks++;
        if (watermark_hit !== 1'b1) begin
            errors++;
            $display("FAIL wm_reach got %b want 1", watermark_hit);
        end
        pop_expect("wm_rd", 8'h01);
        checks++;
        if (watermark_hit !== 1'b0) begin
            errors++;
            $display("FAIL wm_fall got %b want 0", watermark_hit);
        end
        push(8'h04);
        push(8'h05);
        watermark = 3'd0;
        #1;
        checks++;
        if (watermark_hit !== 1'b0 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL wm_zero wh=%b c=%0d want 0 4", watermark_hit, fifo_count);
        end
    endtask

    task automatic test_disabled();
        do_reset();
        mode = 2'b00;
        push(8'hD0);
        mode = 2'b11;
        push(8'hD1);
        checks++;
        if (fifo_count !== 3'd0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL disabled_wr c=%0d ov=%b want 0 0", fifo_count, overrun);
        end
        mode = 2'b01;
        push(8'hD2);
        push(8'hD3);
        mode = 2'b00;
        pop_expect("disabled_rd", 8'hD2);
        checks++;
        if (fifo_count !== 3'd1 || data_rd !== 8'hD3) begin
            errors++;
            $display("FAIL disabled_pop c=%0d d=%h want 1 d3", fifo_count, data_rd);
        end
    endtask

    task automatic test_flush();
        do_reset();
        mode = 2'b01;
        for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i));
        pop_expect("flush_pre", 8'hE0);
        checks++;
        if (fifo_count !== 3'd3 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre c=%0d ov=%b want 3 1", fifo_count, overrun);
        end
        flush = 1'b1; write = 1'b1; data_wr = 8'hEE;
        cyc();
        flush = 1'b0; write = 1'b0;
        cyc();
        checks++;
        if (fifo_count !== 3'd0 || fifo_empty !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL flush c=%0d e=%b ov=%b want 0 1 0", fifo_count, fifo_empty, overrun);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        mode = 2'b01;
        push(8'h50);
        push(8'h51);
        for (int i = 0; i < 10; i++) begin
            push(8'h60 + 8'(i));
            if (i == 0) pop_expect("wrap_pre0", 8'h50);
            else if (i == 1) pop_expect("wrap_pre1", 8'h51);
            else pop_expect("wrap", 8'h60 + 8'(i - 2));
        end
        checks++;
        if (fifo_count !== 3'd2 || data_rd !== 8'h68) begin
            errors++;
            $display("FAIL wrap_end c=%0d d=%h want 2 68", fifo_count, data_rd);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; mode = 2'b00; watermark = '0;
        write = 1'b0; read = 1'b0; data_wr = '0;
        test_reset();
        test_order();
        test_oldest_full();
        test_stream();
        test_simul_full();
        test_empty_rw();
        test_watermark();
        test_disabled();
        test_flush();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
